lcplc_input_sequencer: RTL

// - Front-end controller for the LCPLC coder. Accepts a raw, untagged sample stream in

---
 rtl/lcplc_input_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/lcplc_input_sequencer.sv
// Front-end sequencer for the LCPLC coder: tags a raw block-sequential sample
// stream with end-of-row / slice / band-stack / image flags for one image.
module lcplc_input_sequencer #(
    parameter int unsigned DATA_WIDTH         = 16,
    parameter int unsigned MAX_SLICE_SIZE_LOG = 8,
    parameter int unsigned SIDE_WIDTH         = 5,
    parameter int unsigned BAND_WIDTH         = 8,
    parameter int unsigned BLOCK_WIDTH        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic [SIDE_WIDTH-1:0]  cfg_cols_m1,
    input  logic [SIDE_WIDTH-1:0]  cfg_rows_m1,
    input  logic [BAND_WIDTH-1:0]  cfg_bands_m1,
    input  logic [BLOCK_WIDTH-1:0] cfg_blocks_m1,
    output logic                   busy,
    output logic                   done,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_last_r,
    output logic                   m_last_s,
    output logic                   m_last_b,
    output logic                   m_last_i
);

    // A full-size coder slice must be expressible with the side fields.
    if (MAX_SLICE_SIZE_LOG > 2 * SIDE_WIDTH) begin : g_bad_geometry
        $error("SIDE_WIDTH too narrow to describe a maximum-size slice");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SIDE_WIDTH-1:0]  cols_q, rows_q, col_q, row_q;
    logic [BAND_WIDTH-1:0]  bands_q, band_q;
    logic [BLOCK_WIDTH-1:0] blocks_q, block_q;

    logic s_hs_c, m_hs_c;
    logic last_r_c, last_s_c, last_b_c, last_i_c;
    logic start_c;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshakes and flag decode from the current counters.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        start_c   = 1'b0;

        last_r_c = (col_q == cols_q);
        last_s_c = last_r_c && (row_q == rows_q);
        last_b_c = last_s_c && (band_q == bands_q);
        last_i_c = last_b_c && (block_q == blocks_q);

        if (state == ST_RUN) begin
            s_ready = !m_valid || m_ready;
        end
        s_hs_c = s_valid && s_ready;
        m_hs_c = m_valid && m_ready;

        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    start_c   = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (s_hs_c && last_i_c) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (m_hs_c && m_last_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Geometry capture at image start and position counters advanced per accepted sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cols_q   <= '0;
            rows_q   <= '0;
            bands_q  <= '0;
            blocks_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            band_q   <= '0;
            block_q  <= '0;
        end else if (start_c) begin
            cols_q   <= cfg_cols_m1;
            rows_q   <= cfg_rows_m1;
            bands_q  <= cfg_bands_m1;
            blocks_q <= cfg_blocks_m1;
            col_q    <= '0;
            row_q    <= '0;
            band_q   <= '0;
            block_q  <= '0;
        end else if (s_hs_c) begin
            if (last_i_c) begin
                col_q   <= '0;
                row_q   <= '0;
                band_q  <= '0;
                block_q <= '0;
            end else if (last_b_c) begin
                col_q   <= '0;
                row_q   <= '0;
                band_q  <= '0;
                block_q <= block_q + BLOCK_WIDTH'(1);
            end else if (last_s_c) begin
                col_q  <= '0;
                row_q  <= '0;
                band_q <= band_q + BAND_WIDTH'(1);
            end else if (last_r_c) begin
                col_q <= '0;
                row_q <= row_q + SIDE_WIDTH'(1);
            end else begin
                col_q <= col_q + SIDE_WIDTH'(1);
            end
        end
    end

    // Single output register stage; word and flags hold until taken downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last_r <= 1'b0;
            m_last_s <= 1'b0;
            m_last_b <= 1'b0;
            m_last_i <= 1'b0;
        end else if (s_hs_c) begin
            m_valid  <= 1'b1;
            m_data   <= s_data;
            m_last_r <= last_r_c;
            m_last_s <= last_s_c;
            m_last_b <= last_b_c;
            m_last_i <= last_i_c;
        end else if (m_hs_c) begin
            m_valid <= 1'b0;
        end
    end

    // Status: busy follows the next state, done marks the image's final output handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
            done <= (state == ST_FLUSH) && m_hs_c && m_last_i;
        end
    end

endmodule
